// File: rtl/led_afterglow_if.sv
// rtl/led_afterglow_if.sv - chaser pattern in, PWM LED drive out
interface led_afterglow_if #(
    parameter int N_LED = 8
);
    logic [N_LED-1:0] PATTERN;
    logic             ENABLE;
    logic [N_LED-1:0] LED;
    logic             PWM_WRAP;

    // Upstream side: the chaser and the enable source
    modport master (
        output PATTERN,
        output ENABLE,
        input  LED,
        input  PWM_WRAP
    );

    // Afterglow side
    modport slave (
        input  PATTERN,
        input  ENABLE,
        output LED,
        output PWM_WRAP
    );
endinterface

// File: rtl/led_afterglow.sv
// rtl/led_afterglow.sv - PWM LED driver with linear fade-out afterglow
module led_afterglow #(
    parameter int N_LED      = 8,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_BITS = 16,
    parameter int DECAY_STEP = 8
) (
    input  logic          CLK,
    input  logic          RESET_N,
    led_afterglow_if.slave bus
);
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam int                  MAX_INT   = (2 ** PWM_BITS) - 1;
    // A step larger than full scale can never be subtracted; the saturating branch handles it.
    localparam bit                  STEP_FITS = (DECAY_STEP <= MAX_INT);
    localparam logic [PWM_BITS-1:0] STEP_W    = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0]              pwm_cnt_q, pwm_cnt_d;
    logic [DECAY_BITS-1:0]            prescaler_q, prescaler_d;
    logic [N_LED-1:0][PWM_BITS-1:0]   level_q, level_d;
    logic [N_LED-1:0][PWM_BITS-1:0]   duty_q, duty_d;
    logic [N_LED-1:0]                 led_q, led_d;
    logic                             pwm_wrap_q, pwm_wrap_d;
    logic                             decay_tick;
    logic                             period_end;

    // Next-state for counters, per-channel level/duty and the registered outputs
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        prescaler_d = prescaler_q + DECAY_BITS'(1);
        decay_tick  = &prescaler_q;
        period_end  = (pwm_cnt_q == MAX);
        pwm_wrap_d  = period_end;
        level_d     = level_q;
        duty_d      = duty_q;
        led_d       = '0;
        for (int i = 0; i < N_LED; i++) begin
            // Duty samples the level as it stood before this cycle's update
            if (period_end) begin
                duty_d[i] = level_q[i];
            end
            // A lit pattern bit always re-arms full brightness, even on a decay tick
            if (bus.PATTERN[i]) begin
                level_d[i] = MAX;
            end else if (decay_tick) begin
                if (STEP_FITS && (level_q[i] >= STEP_W)) begin
                    level_d[i] = level_q[i] - STEP_W;
                end else begin
                    level_d[i] = '0;
                end
            end
            if (bus.ENABLE) begin
                led_d[i] = (duty_q[i] == MAX) || (pwm_cnt_q < duty_q[i]);
            end else begin
                led_d[i] = bus.PATTERN[i];
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt_q   <= '0;
            prescaler_q <= '0;
            level_q     <= '0;
            duty_q      <= '0;
            led_q       <= '0;
            pwm_wrap_q  <= 1'b0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            prescaler_q <= prescaler_d;
            level_q     <= level_d;
            duty_q      <= duty_d;
            led_q       <= led_d;
            pwm_wrap_q  <= pwm_wrap_d;
        end
    end

    assign bus.LED      = led_q;
    assign bus.PWM_WRAP = pwm_wrap_q;
endmodule
